mem_port_arbiter: RTL and testbench

Two-port to one-port memory arbiter that sits directly downstream of the pipelined CPU datapath. It accepts the datapath's instruction-fetch request (imem_*) and data-access request (dmem_*), serializes them onto a single shared memory/cache port (mem_*), and routes each response back to its requester. It uses the same strobe/cycle/resp/retry handshake on both sides, so the datapath needs no changes.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter merging instruction-fetch and data-access
//            requests onto one shared strobe/cycle/ack/retry memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] imem_address,
    input  logic              imem_action_stb,
    input  logic              imem_action_cyc,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_resp,
    output logic              imem_retry,

    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_write,
    input  logic [SEL_W-1:0]  dmem_byte_enable,
    input  logic              dmem_action_stb,
    input  logic              dmem_action_cyc,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              dmem_retry,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [SEL_W-1:0]  mem_sel,
    output logic              mem_stb,
    output logic              mem_cyc,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              mem_rty
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_I = 3'd1,
        S_GRANT_D = 3'd2,
        S_RETRY_I = 3'd3,
        S_RETRY_D = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic              r_cmd_we;
    logic [SEL_W-1:0]  r_cmd_sel;
    logic              r_stb;
    logic              r_cyc;

    logic w_imem_req;
    logic w_dmem_req;
    logic w_pick_d;
    logic w_grant_i;
    logic w_grant_d;

    assign w_imem_req = imem_action_stb & imem_action_cyc;
    assign w_dmem_req = dmem_action_stb & dmem_action_cyc;
    // On a tie the port that did not win last time is served.
    assign w_pick_d   = w_dmem_req & (~w_imem_req | ~r_last_d);
    assign w_grant_i  = (r_state == S_GRANT_I);
    assign w_grant_d  = (r_state == S_GRANT_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_we    <= 1'b0;
            r_cmd_sel   <= '0;
            r_stb       <= 1'b0;
            r_cyc       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_d) begin
                        r_cmd_addr  <= dmem_address;
                        r_cmd_wdata <= dmem_wdata;
                        r_cmd_we    <= dmem_write;
                        r_cmd_sel   <= dmem_byte_enable;
                        r_last_d    <= 1'b1;
                        r_stb       <= 1'b1;
                        r_cyc       <= 1'b1;
                        r_state     <= S_GRANT_D;
                    end else if (w_imem_req) begin
                        r_cmd_addr  <= imem_address;
                        r_cmd_we    <= 1'b0;
                        r_cmd_sel   <= '1;
                        r_last_d    <= 1'b0;
                        r_stb       <= 1'b1;
                        r_cyc       <= 1'b1;
                        r_state     <= S_GRANT_I;
                    end
                end
                S_GRANT_I: begin
                    // Ack beats both abort and retry.
                    if (mem_ack || !w_imem_req) begin
                        r_stb   <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (mem_rty) begin
                        r_stb   <= 1'b0;
                        r_state <= S_RETRY_I;
                    end
                end
                S_GRANT_D: begin
                    if (mem_ack || !w_dmem_req) begin
                        r_stb   <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (mem_rty) begin
                        r_stb   <= 1'b0;
                        r_state <= S_RETRY_D;
                    end
                end
                S_RETRY_I: begin
                    if (!w_imem_req) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_stb   <= 1'b1;
                        r_state <= S_GRANT_I;
                    end
                end
                S_RETRY_D: begin
                    if (!w_dmem_req) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_stb   <= 1'b1;
                        r_state <= S_GRANT_D;
                    end
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_cyc   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_address = r_cmd_addr;
    assign mem_wdata   = r_cmd_wdata;
    assign mem_we      = r_cmd_we;
    assign mem_sel     = r_cmd_sel;
    assign mem_stb     = r_stb;
    assign mem_cyc     = r_cyc;

    // Responses pass straight through from the memory in the granted cycle.
    assign imem_resp  = w_grant_i & mem_ack;
    assign dmem_resp  = w_grant_d & mem_ack;
    assign imem_retry = w_grant_i & mem_rty & ~mem_ack & w_imem_req;
    assign dmem_retry = w_grant_d & mem_rty & ~mem_ack & w_dmem_req;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst;
    logic [15:0]  imem_address;
    logic         imem_action_stb, imem_action_cyc;
    logic [127:0] imem_rdata;
    logic         imem_resp, imem_retry;
    logic [15:0]  dmem_address;
    logic [127:0] dmem_wdata;
    logic         dmem_write;
    logic [15:0]  dmem_byte_enable;
    logic         dmem_action_stb, dmem_action_cyc;
    logic [127:0] dmem_rdata;
    logic         dmem_resp, dmem_retry;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_we;
    logic [15:0]  mem_sel;
    logic         mem_stb, mem_cyc;
    logic [127:0] mem_rdata;
    logic         mem_ack, mem_rty;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .imem_address     (imem_address),
        .imem_action_stb  (imem_action_stb),
        .imem_action_cyc  (imem_action_cyc),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .imem_retry       (imem_retry),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_action_stb  (dmem_action_stb),
        .dmem_action_cyc  (dmem_action_cyc),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_retry       (dmem_retry),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_sel          (mem_sel),
        .mem_stb          (mem_stb),
        .mem_cyc          (mem_cyc),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .mem_rty          (mem_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_address = '0; imem_action_stb = 1'b0; imem_action_cyc = 1'b0;
        dmem_address = '0; dmem_wdata = '0; dmem_write = 1'b0; dmem_byte_enable = '0;
        dmem_action_stb = 1'b0; dmem_action_cyc = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0; mem_rty = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        mem_ack = 1'b1; mem_rty = 1'b1; mem_rdata = {4{32'hdead_beef}};
        tick(); tick();
        @(negedge clk);
        total++;
        if ({mem_stb, mem_cyc, mem_we, mem_sel, mem_address, mem_wdata} !== '0) begin
            bad++; $display("FAIL reset_mem_outputs: got stb=%b cyc=%b we=%b sel=%h addr=%h want all zero",
                            mem_stb, mem_cyc, mem_we, mem_sel, mem_address);
        end
        total++;
        if ({imem_resp, dmem_resp, imem_retry, dmem_retry} !== 4'b0 || imem_rdata !== '0 || dmem_rdata !== '0) begin
            bad++; $display("FAIL reset_resp_outputs: got iresp=%b dresp=%b iretry=%b dretry=%b want 0",
                            imem_resp, dmem_resp, imem_retry, dmem_retry);
        end
        tick();
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic [127:0] rd;
        rd = 128'h0123_4567_89ab_cdef_0000_1111_2222_beef;
        imem_address = 16'h0040; imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
        @(negedge clk);
        total++;
        if (mem_stb !== 1'b0) begin bad++; $display("FAIL fetch_pre_stb: got %b want 0", mem_stb); end
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 2); mem_rdata = rd;
            @(negedge clk);
            total++;
            if ({mem_stb, mem_cyc, mem_we, mem_sel, mem_address} !== {1'b1, 1'b1, 1'b0, 16'hffff, 16'h0040}) begin
                bad++; $display("FAIL fetch_cmd[%0d]: got stb=%b cyc=%b we=%b sel=%h addr=%h want 1 1 0 ffff 0040",
                                i, mem_stb, mem_cyc, mem_we, mem_sel, mem_address);
            end
            total++;
            if ({imem_resp, dmem_resp} !== {(i == 2), 1'b0}) begin
                bad++; $display("FAIL fetch_resp[%0d]: got iresp=%b dresp=%b want %b 0", i, imem_resp, dmem_resp, (i == 2));
            end
            if (i == 2) begin
                total++;
                if (imem_rdata !== rd || dmem_rdata !== '0) begin
                    bad++; $display("FAIL fetch_rdata: got i=%h d=%h want i=%h d=0", imem_rdata, dmem_rdata, rd);
                end
            end
            tick();
        end
        imem_action_stb = 1'b0; imem_action_cyc = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_stb, mem_cyc, imem_resp} !== 3'b000 || imem_rdata !== '0) begin
            bad++; $display("FAIL fetch_after: got stb=%b cyc=%b iresp=%b rdata=%h want 0", mem_stb, mem_cyc, imem_resp, imem_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        is_d;
        logic [15:0] e_addr, e_sel;
        apply_reset();
        dmem_address = 16'h2000; dmem_write = 1'b1; dmem_wdata = 128'h1234; dmem_byte_enable = 16'h0003;
        dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
        imem_address = 16'h0010; imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
        mem_ack = 1'b1; mem_rdata = 128'hcafe;
        for (int g = 0; g < 4; g++) begin
            is_d   = (g % 2 == 0);
            e_addr = is_d ? 16'h2000 : 16'h0010;
            e_sel  = is_d ? 16'h0003 : 16'hffff;
            @(negedge clk);
            total++;
            if (mem_stb !== 1'b0) begin bad++; $display("FAIL b2b_gap[%0d]: got stb=%b want 0", g, mem_stb); end
            tick();
            @(negedge clk);
            total++;
            if ({mem_stb, mem_we, mem_sel, mem_address} !== {1'b1, is_d, e_sel, e_addr}) begin
                bad++; $display("FAIL b2b_grant[%0d]: got stb=%b we=%b sel=%h addr=%h want 1 %b %h %h",
                                g, mem_stb, mem_we, mem_sel, mem_address, is_d, e_sel, e_addr);
            end
            total++;
            if ({imem_resp, dmem_resp} !== {~is_d, is_d}) begin
                bad++; $display("FAIL b2b_resp[%0d]: got iresp=%b dresp=%b want %b %b", g, imem_resp, dmem_resp, ~is_d, is_d);
            end
            if (is_d) begin
                total++;
                if (mem_wdata !== 128'h1234) begin bad++; $display("FAIL b2b_wdata[%0d]: got %h want 1234", g, mem_wdata); end
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_retry();
        logic [4:0] ack_seq, rty_seq, stb_exp, retry_exp;
        ack_seq = 5'b10000; rty_seq = 5'b00111; stb_exp = 5'b10101; retry_exp = 5'b00101;
        imem_address = 16'h0100; imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_ack = ack_seq[i]; mem_rty = rty_seq[i]; mem_rdata = 128'h77;
            @(negedge clk);
            total++;
            if ({mem_stb, mem_cyc, mem_address} !== {stb_exp[i], 1'b1, 16'h0100}) begin
                bad++; $display("FAIL retry_cmd[%0d]: got stb=%b cyc=%b addr=%h want %b 1 0100", i, mem_stb, mem_cyc, mem_address, stb_exp[i]);
            end
            total++;
            if ({imem_retry, imem_resp} !== {retry_exp[i], ack_seq[i]}) begin
                bad++; $display("FAIL retry_pulse[%0d]: got retry=%b resp=%b want %b %b", i, imem_retry, imem_resp, retry_exp[i], ack_seq[i]);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        total++;
        if ({mem_stb, mem_cyc, imem_retry, imem_resp} !== 4'b0000) begin
            bad++; $display("FAIL retry_end: got stb=%b cyc=%b retry=%b resp=%b want 0", mem_stb, mem_cyc, imem_retry, imem_resp);
        end
        tick();
    endtask

    task automatic test_ack_rty_same_cycle();
        dmem_address = 16'h3000; dmem_write = 1'b0; dmem_byte_enable = 16'h00f0;
        dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rty = 1'b1; mem_rdata = 128'h5a5a;
        @(negedge clk);
        total++;
        if ({dmem_resp, dmem_retry, imem_resp, mem_we, mem_address} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h3000}) begin
            bad++; $display("FAIL ackrty_resp: got resp=%b retry=%b iresp=%b we=%b addr=%h want 1 0 0 0 3000",
                            dmem_resp, dmem_retry, imem_resp, mem_we, mem_address);
        end
        total++;
        if (dmem_rdata !== 128'h5a5a) begin bad++; $display("FAIL ackrty_rdata: got %h want 5a5a", dmem_rdata); end
        tick();
        dmem_action_stb = 1'b0; dmem_action_cyc = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_stb, mem_cyc, dmem_retry} !== 3'b000) begin
            bad++; $display("FAIL ackrty_idle: got stb=%b cyc=%b retry=%b want 0", mem_stb, mem_cyc, dmem_retry);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_abort();
        imem_address = 16'h0200; imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({mem_stb, mem_address} !== {1'b1, 16'h0200}) begin
            bad++; $display("FAIL abort_grant: got stb=%b addr=%h want 1 0200", mem_stb, mem_address);
        end
        tick();
        imem_action_cyc = 1'b0;
        @(negedge clk);
        total++;
        if ({imem_resp, imem_retry} !== 2'b00) begin
            bad++; $display("FAIL abort_drop: got resp=%b retry=%b want 0 0", imem_resp, imem_retry);
        end
        tick();
        dmem_address = 16'h4000; dmem_write = 1'b1; dmem_wdata = 128'habcd; dmem_byte_enable = 16'h00ff;
        dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_stb, mem_cyc, imem_resp, dmem_resp} !== 4'b0000) begin
            bad++; $display("FAIL abort_idle: got stb=%b cyc=%b iresp=%b dresp=%b want 0", mem_stb, mem_cyc, imem_resp, dmem_resp);
        end
        tick();
        @(negedge clk);
        total++;
        if ({mem_stb, mem_we, mem_sel, mem_address, dmem_resp} !== {1'b1, 1'b1, 16'h00ff, 16'h4000, 1'b1}) begin
            bad++; $display("FAIL abort_next: got stb=%b we=%b sel=%h addr=%h dresp=%b want 1 1 00ff 4000 1",
                            mem_stb, mem_we, mem_sel, mem_address, dmem_resp);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        dmem_address = 16'h5000; dmem_write = 1'b1; dmem_wdata = 128'h55; dmem_byte_enable = 16'h0f0f;
        dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({mem_stb, mem_address} !== {1'b1, 16'h5000}) begin
            bad++; $display("FAIL rstmid_grant: got stb=%b addr=%h want 1 5000", mem_stb, mem_address);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 128'h99;
        imem_address = 16'h0600; imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_stb, mem_cyc, mem_we, mem_sel, mem_address, mem_wdata} !== '0) begin
            bad++; $display("FAIL rstmid_mem_zero: got stb=%b cyc=%b we=%b sel=%h addr=%h want all zero",
                            mem_stb, mem_cyc, mem_we, mem_sel, mem_address);
        end
        total++;
        if ({imem_resp, dmem_resp, imem_retry, dmem_retry} !== 4'b0 || dmem_rdata !== '0) begin
            bad++; $display("FAIL rstmid_late_ack: got iresp=%b dresp=%b want 0 0", imem_resp, dmem_resp);
        end
        tick();
        @(negedge clk);
        total++;
        if ({mem_address, dmem_resp, imem_resp} !== {16'h5000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rstmid_tie: got addr=%h dresp=%b iresp=%b want 5000 1 0", mem_address, dmem_resp, imem_resp);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int           owner;  // 0 none, 1 fetch, 2 data
        bit           gap, last_d, i_act, d_act, i_done, d_done, ireq, dreq, req;
        logic [15:0]  e_addr, e_sel;
        logic [127:0] e_wdata;
        logic         e_we, e_stb, e_cyc, e_iresp, e_dresp, e_iretry, e_dretry;
        owner = 0; gap = 0; last_d = 0; i_act = 0; d_act = 0; i_done = 0; d_done = 0;
        e_addr = '0; e_sel = '0; e_wdata = '0; e_we = 1'b0;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if (i_act) begin
                if (i_done || $urandom_range(0, 15) == 0) begin
                    i_act = 0;
                    if ($urandom_range(0, 1) == 1) imem_action_stb = 1'b0; else imem_action_cyc = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_act = 1; imem_address = 16'($urandom);
                imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
            end
            if (d_act) begin
                if (d_done || $urandom_range(0, 15) == 0) begin
                    d_act = 0;
                    if ($urandom_range(0, 1) == 1) dmem_action_stb = 1'b0; else dmem_action_cyc = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_act = 1; dmem_address = 16'($urandom); dmem_write = 1'($urandom);
                dmem_wdata = {$urandom, $urandom, $urandom, $urandom}; dmem_byte_enable = 16'($urandom);
                dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
            end
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rty   = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            rst       = ($urandom_range(0, 63) == 0);
            ireq = imem_action_stb & imem_action_cyc;
            dreq = dmem_action_stb & dmem_action_cyc;

            e_cyc    = (owner != 0);
            e_stb    = (owner != 0) && !gap;
            e_iresp  = (owner == 1) && !gap && mem_ack;
            e_dresp  = (owner == 2) && !gap && mem_ack;
            e_iretry = (owner == 1) && !gap && !mem_ack && mem_rty && ireq;
            e_dretry = (owner == 2) && !gap && !mem_ack && mem_rty && dreq;

            @(negedge clk);
            total++;
            if ({mem_stb, mem_cyc, imem_resp, dmem_resp, imem_retry, dmem_retry} !==
                {e_stb, e_cyc, e_iresp, e_dresp, e_iretry, e_dretry}) begin
                bad++; $display("FAIL rand_ctrl[%0d]: got stb,cyc,ir,dr,irty,drty=%b%b%b%b%b%b want %b%b%b%b%b%b", c,
                                mem_stb, mem_cyc, imem_resp, dmem_resp, imem_retry, dmem_retry,
                                e_stb, e_cyc, e_iresp, e_dresp, e_iretry, e_dretry);
            end
            total++;
            if ({mem_address, mem_we, mem_sel} !== {e_addr, e_we, e_sel}) begin
                bad++; $display("FAIL rand_cmd[%0d]: got addr=%h we=%b sel=%h want %h %b %h", c,
                                mem_address, mem_we, mem_sel, e_addr, e_we, e_sel);
            end
            if (e_we) begin
                total++;
                if (mem_wdata !== e_wdata) begin
                    bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", c, mem_wdata, e_wdata);
                end
            end
            total++;
            if (imem_rdata !== (e_iresp ? mem_rdata : 128'h0) || dmem_rdata !== (e_dresp ? mem_rdata : 128'h0)) begin
                bad++; $display("FAIL rand_rdata[%0d]: got i=%h d=%h", c, imem_rdata, dmem_rdata);
            end

            if (rst) begin
                owner = 0; gap = 0; last_d = 0;
                e_addr = '0; e_sel = '0; e_wdata = '0; e_we = 1'b0;
            end else if (owner == 0) begin
                if (dreq && (!ireq || !last_d)) begin
                    owner = 2; last_d = 1;
                    e_addr = dmem_address; e_we = dmem_write; e_sel = dmem_byte_enable; e_wdata = dmem_wdata;
                end else if (ireq) begin
                    owner = 1; last_d = 0;
                    e_addr = imem_address; e_we = 1'b0; e_sel = 16'hffff;
                end
            end else begin
                req = (owner == 1) ? ireq : dreq;
                if (gap) begin
                    gap = 0;
                    if (!req) owner = 0;
                end else if (mem_ack || !req) begin
                    owner = 0;
                end else if (mem_rty) begin
                    gap = 1;
                end
            end
            i_done = e_iresp;
            d_done = e_dresp;
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_retry();
        test_ack_rty_same_cycle();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
